instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage between the program-counter register and decode. It drives the PC register's next value and write enable, issues in-order reads to instruction memory, and buffers returned instructions with their PCs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from execute (branch or jump) flushes the buffer and discards stale memory responses.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered fetches; power of two, at least 2
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  reset, synchronous, active-high
- PC  in  32  current PC register output
- PC_NEXT  out  32  next PC value, feeding the PC register's DIN
- PC_WRITE  out  1  PC register write enable
- IMEM_ADDR  out  32  fetch address; always equals PC
- IMEM_REQ  out  1  fetch request
- IMEM_GNT  in  1  memory accepts the request this cycle
- IMEM_RDATA  in  32  returned instruction word
- IMEM_RVALID  in  1  response valid; responses arrive in order, at least 1 cycle after grant
- REDIRECT  in  1  control-flow redirect this cycle
- REDIRECT_PC  in  32  redirect target
- IR  out  32  instruction at FIFO head
- IR_PC  out  32  PC of the instruction at FIFO head
- IR_VALID  out  1  FIFO not empty
- DEC_READY  in  1  decode accepts the head this cycle

## Operation
- State consists of three counters; there is no explicit FSM.
  - FIFO occupancy `occ`, range 0..DEPTH
  - outstanding request count `out`, range 0..DEPTH
  - stale-response drop count `drop`, range 0..`out`
  - Counter width is $clog2(DEPTH)+1.
- `pop` = IR_VALID & DEC_READY & !REDIRECT.
- Issue rule: IMEM_REQ = !RESET & !REDIRECT & (`occ` + (`out` − `drop`) − `pop` < DEPTH). The stale-response term uses current-cycle values. IMEM_REQ may depend combinationally on DEC_READY.
- Accepted fetch (IMEM_REQ & IMEM_GNT):
  - PC_WRITE = 1 and PC_NEXT = PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - The fetch PC is pushed onto an internal DEPTH-entry in-flight PC queue.
  - `out` increments.
- Response (IMEM_RVALID & `out` > 0):
  - The in-flight PC queue is popped and `out` decrements.
  - If `drop` > 0: the response is discarded and `drop` decrements.
  - Otherwise {in-flight PC, IMEM_RDATA} is pushed into the FIFO.
  - IMEM_RVALID while `out` == 0 is ignored.
- Redirect (REDIRECT = 1):
  - PC_WRITE = 1 and PC_NEXT = {REDIRECT_PC[31:2], 2'b00}.
  - No request is issued that cycle.
  - The FIFO is emptied, and any pop that cycle is void.
  - `drop` is set to the post-cycle `out`. A response arriving in the redirect cycle is also discarded.
- No fetch and no redirect: PC_WRITE = 0 and PC_NEXT = PC + 4.
- FIFO behaviour:
  - IR and IR_PC hold stable while IR_VALID & !DEC_READY.
  - A simultaneous push and pop with `occ` == DEPTH is legal.
  - A push with `occ` == DEPTH and no pop cannot occur because of the issue rule.
- Priority: RESET > REDIRECT > normal fetch/pop.
- Reset:
  - `occ`, `out` and `drop` become 0, and the FIFO and in-flight queue are cleared.
  - IR_VALID = 0, IR = 32'h00000013 (NOP), IR_PC = 0.
  - IMEM_REQ = 0 and PC_WRITE = 0 while RESET is high. The PC register resets itself.
  - Reset mid-operation abandons all in-flight requests. Later responses are ignored under the `out` == 0 rule.

## Timing
- Fetch accepted in cycle N: PC holds the new value in cycle N+1.
- Back-to-back fetches: one per cycle while credit and grant allow.
- Response in cycle M: IR_VALID rises in cycle M+1. There is no bypass.
- Latency from grant to IR_VALID is memory latency + 1. With 1-cycle memory this is 2 cycles.
- Full throughput (one instruction per cycle) requires DEPTH ≥ memory latency + 1.
- Redirect in cycle R:
  - IR_VALID = 0 in R+1.
  - The first request from the target is issued in R+1, with IMEM_ADDR = target.
  - The target instruction appears no earlier than R+3 with 1-cycle memory.
- First request after RESET falls: the first cycle with RESET low. The PC is 0 at that point.

## Test plan
- Reset, 1-cycle memory, IMEM_GNT = 1, DEC_READY = 1 -> fetches at 0x0, 0x4, 0x8 on consecutive cycles; IR_VALID from cycle 2; one instruction per cycle with IR_PC matching.
- DEC_READY = 0 for 10 cycles -> fetches stop when `occ` + `out` = 4; IR and IR_PC hold; on release there is no loss or duplication, and order is preserved.
- 3-cycle memory latency with 2 outstanding at 0x10 and 0x14, then REDIRECT to 0x100 -> FIFO empties, both stale responses are dropped, and the next IR_PC is 0x100 with the correct data.
- REDIRECT_PC = 0x103 -> PC_NEXT = 0x100; REDIRECT held together with DEC_READY = 1 while IR_VALID = 1 -> no pop is counted, and the head is flushed.
- PC = 0xFFFFFFFC fetch -> PC_NEXT = 0x00000000; IMEM_GNT = 0 -> PC_WRITE = 0 and PC is unchanged.
- RESET asserted with 2 responses pending -> IR_VALID = 0 and IR = 0x00000013 after the edge; late IMEM_RVALID pulses are ignored; fetch restarts at 0x0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC register, instruction memory, redirect and decode sides.
// Pure wiring, no latency of its own.
// Backpressure flows through IMEM_GNT (memory side) and DEC_READY (decode side).
interface instr_fetch_if;
  logic [31:0] PC;
  logic [31:0] PC_NEXT;
  logic        PC_WRITE;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_GNT;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_RVALID;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_VALID;
  logic        DEC_READY;

  // Fetch stage side
  modport master (
    input  PC,
    output PC_NEXT, PC_WRITE,
    output IMEM_ADDR, IMEM_REQ,
    input  IMEM_GNT, IMEM_RDATA, IMEM_RVALID,
    input  REDIRECT, REDIRECT_PC,
    output IR, IR_PC, IR_VALID,
    input  DEC_READY
  );

  // Surrounding pipeline / memory side
  modport slave (
    output PC,
    input  PC_NEXT, PC_WRITE,
    input  IMEM_ADDR, IMEM_REQ,
    output IMEM_GNT, IMEM_RDATA, IMEM_RVALID,
    output REDIRECT, REDIRECT_PC,
    input  IR, IR_PC, IR_VALID,
    output DEC_READY
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the PC register, issues in-order memory reads, buffers {PC, instr}.
// Grant to IR_VALID is memory latency + 1 cycle; no response bypass.
// Requests stop when buffered + live in-flight fetches would exceed DEPTH; decode stalls via DEC_READY.
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input logic           CLK,
  input logic           RESET,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  // Occupancy, outstanding requests, and responses still to be thrown away
  logic [CW-1:0] occ_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_nxt;

  // Instruction buffer and the queue of PCs whose responses are still pending
  logic [31:0]   ir_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ifq    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ifq_wr;
  logic [AW-1:0] ifq_rd;

  logic          pop;
  logic          rsp;
  logic          push;
  logic          fetch;
  logic          credit_ok;
  logic [CW:0]   live;

  assign bus.IR_VALID  = (occ_cnt != '0);
  assign bus.IR        = bus.IR_VALID ? ir_mem[rd_ptr] : NOP;
  assign bus.IR_PC     = bus.IR_VALID ? pc_mem[rd_ptr] : 32'h0;
  assign bus.IMEM_ADDR = bus.PC;

  assign pop  = bus.IR_VALID & bus.DEC_READY & ~bus.REDIRECT;
  assign rsp  = bus.IMEM_RVALID & (out_cnt != '0);
  assign push = rsp & ~bus.REDIRECT & (drop_cnt == '0);

  // Buffered plus live in-flight entries, crediting a pop in this same cycle.
  // Stale responses do not occupy buffer space, so they are excluded.
  assign live = {1'b0, occ_cnt} + {1'b0, out_cnt} - {1'b0, drop_cnt} - {{CW{1'b0}}, pop};

  // The in-flight PC queue is DEPTH deep, so stale requests still count against it.
  assign credit_ok = (live < DEPTH_W) & ((out_cnt < DEPTH_C) | rsp);

  assign bus.IMEM_REQ = ~RESET & ~bus.REDIRECT & credit_ok;
  assign fetch        = bus.IMEM_REQ & bus.IMEM_GNT;
  assign out_nxt      = out_cnt + CW'(fetch) - CW'(rsp);

  // Next-PC select: redirect target (word aligned) wins over sequential fetch
  always_comb begin
    bus.PC_NEXT  = bus.PC + 32'd4;
    bus.PC_WRITE = 1'b0;
    if (!RESET) begin
      if (bus.REDIRECT) begin
        bus.PC_NEXT  = {bus.REDIRECT_PC[31:2], 2'b00};
        bus.PC_WRITE = 1'b1;
      end else if (fetch) begin
        bus.PC_WRITE = 1'b1;
      end
    end
  end

  // Counters and pointers; a redirect empties the buffer and marks all outstanding as stale
  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ_cnt  <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ifq_wr   <= '0;
      ifq_rd   <= '0;
    end else begin
      out_cnt <= out_nxt;
      if (fetch) ifq_wr <= ifq_wr + AW'(1);
      if (rsp)   ifq_rd <= ifq_rd + AW'(1);
      if (bus.REDIRECT) begin
        occ_cnt  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop_cnt <= out_nxt;
      end else begin
        if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        occ_cnt <= occ_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage writes; contents are only observed through valid pointers, so no reset
  always_ff @(posedge CLK) begin
    if (!RESET && fetch) ifq[ifq_wr] <= bus.PC;
    if (!RESET && push) begin
      ir_mem[wr_ptr] <= bus.IMEM_RDATA;
      pc_mem[wr_ptr] <= ifq[ifq_rd];
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC register model and an in-order memory model.
// Memory latency is programmable; memory data for address A is A + 0x10000000.
// Each scenario task drives cycles at the falling edge and checks shortly after.
module tb_instr_fetch;
  logic CLK;
  logic RESET;
  logic mem_flush;
  logic force_rv;
  int   lat = 1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  instr_fetch_if bus();

  instr_fetch #(.DEPTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PC register: resets to 0, loads PC_NEXT when enabled
  always @(posedge CLK) begin
    if (RESET) bus.PC <= 32'h0;
    else if (bus.PC_WRITE) bus.PC <= bus.PC_NEXT;
  end

  // In-order memory: grant in cycle c answers in cycle c+lat
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_flush) mq.delete();
    else if (bus.IMEM_REQ && bus.IMEM_GNT) mq.push_back('{bus.IMEM_ADDR, cyc + lat});
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      bus.IMEM_RVALID <= 1'b1;
      bus.IMEM_RDATA  <= mq[0].addr + 32'h1000_0000;
      void'(mq.pop_front());
    end else begin
      bus.IMEM_RVALID <= force_rv;
      bus.IMEM_RDATA  <= 32'hBAD0_0BAD;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    RESET = 1'b1; mem_flush = 1'b1; force_rv = 1'b0;
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 32'h0;
    @(negedge CLK); @(negedge CLK);
    mem_flush = 1'b0; RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; mem_flush = 1'b1; force_rv = 1'b0; lat = 1;
    bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b1;
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 32'h40;
    @(negedge CLK); #1;
    checks++; if (bus.IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.IMEM_REQ); end
    checks++; if (bus.PC_WRITE !== 1'b0) begin errors++; $display("FAIL reset_pcw: got %b want 0", bus.PC_WRITE); end
    checks++; if (bus.IR_VALID !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.IR_VALID); end
    checks++; if (bus.IR !== 32'h13) begin errors++; $display("FAIL reset_ir: got %h want 00000013", bus.IR); end
    checks++; if (bus.IR_PC !== 32'h0) begin errors++; $display("FAIL reset_irpc: got %h want 0", bus.IR_PC); end
    bus.REDIRECT = 1'b1; #1;
    checks++; if (bus.PC_WRITE !== 1'b0) begin errors++; $display("FAIL reset_over_redirect_pcw: got %b want 0", bus.PC_WRITE); end
    bus.REDIRECT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_stream();
    lat = 1; bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'(4*k)) begin errors++; $display("FAIL stream_fetch c%0d: got req=%b addr=%h want req=1 addr=%h", k, bus.IMEM_REQ, bus.IMEM_ADDR, 32'(4*k)); end
      if (k == 0) begin
        checks++; if (bus.PC_WRITE !== 1'b1 || bus.PC_NEXT !== 32'h4) begin errors++; $display("FAIL stream_pcnext: got pcw=%b next=%h want 1/00000004", bus.PC_WRITE, bus.PC_NEXT); end
      end
      if (k < 2) begin
        checks++; if (bus.IR_VALID !== 1'b0) begin errors++; $display("FAIL stream_early_vld c%0d: got %b want 0", k, bus.IR_VALID); end
      end else begin
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'(4*(k-2)) || bus.IR !== 32'h1000_0000 + 32'(4*(k-2))) begin errors++; $display("FAIL stream_ir c%0d: got vld=%b pc=%h ir=%h want 1 %h %h", k, bus.IR_VALID, bus.IR_PC, bus.IR, 32'(4*(k-2)), 32'h1000_0000 + 32'(4*(k-2))); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_stall();
    lat = 1; bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.DEC_READY = (k >= 10);
      #1;
      if (k < 4) begin
        checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'(4*k)) begin errors++; $display("FAIL stall_fill c%0d: got req=%b addr=%h want 1 %h", k, bus.IMEM_REQ, bus.IMEM_ADDR, 32'(4*k)); end
      end else if (k < 10) begin
        checks++; if (bus.IMEM_REQ !== 1'b0) begin errors++; $display("FAIL stall_noreq c%0d: got %b want 0", k, bus.IMEM_REQ); end
      end else if (k == 10) begin
        checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h10) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h want 1 00000010", bus.IMEM_REQ, bus.IMEM_ADDR); end
      end
      if (k >= 2 && k < 10) begin
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h0 || bus.IR !== 32'h1000_0000) begin errors++; $display("FAIL stall_hold c%0d: got vld=%b pc=%h ir=%h want 1 0 10000000", k, bus.IR_VALID, bus.IR_PC, bus.IR); end
      end else if (k >= 10) begin
        checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'(4*(k-10)) || bus.IR !== 32'h1000_0000 + 32'(4*(k-10))) begin errors++; $display("FAIL stall_drain c%0d: got vld=%b pc=%h ir=%h want 1 %h", k, bus.IR_VALID, bus.IR_PC, bus.IR, 32'(4*(k-10))); end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_redirect_stale();
    lat = 3; bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus.REDIRECT    = (k == 0) || (k == 3);
      bus.REDIRECT_PC = (k == 0) ? 32'h10 : 32'h100;
      #1;
      case (k)
        0: begin checks++; if (bus.IMEM_REQ !== 1'b0 || bus.PC_WRITE !== 1'b1 || bus.PC_NEXT !== 32'h10) begin errors++; $display("FAIL stale_redir0: got req=%b pcw=%b next=%h want 0 1 00000010", bus.IMEM_REQ, bus.PC_WRITE, bus.PC_NEXT); end end
        1: begin checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h10) begin errors++; $display("FAIL stale_fetch10: got req=%b addr=%h want 1 00000010", bus.IMEM_REQ, bus.IMEM_ADDR); end end
        2: begin checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h14) begin errors++; $display("FAIL stale_fetch14: got req=%b addr=%h want 1 00000014", bus.IMEM_REQ, bus.IMEM_ADDR); end end
        3: begin checks++; if (bus.IMEM_REQ !== 1'b0 || bus.PC_NEXT !== 32'h100) begin errors++; $display("FAIL stale_redir: got req=%b next=%h want 0 00000100", bus.IMEM_REQ, bus.PC_NEXT); end end
        4: begin checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h100 || bus.IMEM_RVALID !== 1'b1) begin errors++; $display("FAIL stale_target_req: got req=%b addr=%h rv=%b want 1 00000100 1", bus.IMEM_REQ, bus.IMEM_ADDR, bus.IMEM_RVALID); end end
        8: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h100 || bus.IR !== 32'h1000_0100) begin errors++; $display("FAIL stale_target_ir: got vld=%b pc=%h ir=%h want 1 00000100 10000100", bus.IR_VALID, bus.IR_PC, bus.IR); end end
        9: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h104 || bus.IR !== 32'h1000_0104) begin errors++; $display("FAIL stale_next_ir: got vld=%b pc=%h ir=%h want 1 00000104 10000104", bus.IR_VALID, bus.IR_PC, bus.IR); end end
        default: ;
      endcase
      if (k >= 4 && k <= 7) begin
        checks++; if (bus.IR_VALID !== 1'b0) begin errors++; $display("FAIL stale_dropped c%0d: got vld=%b pc=%h want vld 0", k, bus.IR_VALID, bus.IR_PC); end
      end
      @(negedge CLK);
    end
    bus.REDIRECT = 1'b0;
  endtask

  task automatic test_redirect_pop();
    lat = 1; bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bus.REDIRECT    = (k == 3);
      bus.REDIRECT_PC = 32'h103;
      #1;
      case (k)
        3: begin
          checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h4) begin errors++; $display("FAIL rpop_head: got vld=%b pc=%h want 1 00000004", bus.IR_VALID, bus.IR_PC); end
          checks++; if (bus.PC_NEXT !== 32'h100 || bus.PC_WRITE !== 1'b1 || bus.IMEM_REQ !== 1'b0) begin errors++; $display("FAIL rpop_align: got next=%h pcw=%b req=%b want 00000100 1 0", bus.PC_NEXT, bus.PC_WRITE, bus.IMEM_REQ); end
        end
        4: begin checks++; if (bus.IR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h100) begin errors++; $display("FAIL rpop_flush: got vld=%b req=%b addr=%h want 0 1 00000100", bus.IR_VALID, bus.IMEM_REQ, bus.IMEM_ADDR); end end
        5: begin checks++; if (bus.IR_VALID !== 1'b0) begin errors++; $display("FAIL rpop_empty: got vld=%b want 0", bus.IR_VALID); end end
        6: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h100 || bus.IR !== 32'h1000_0100) begin errors++; $display("FAIL rpop_target: got vld=%b pc=%h ir=%h want 1 00000100 10000100", bus.IR_VALID, bus.IR_PC, bus.IR); end end
        7: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h104) begin errors++; $display("FAIL rpop_target_next: got vld=%b pc=%h want 1 00000104", bus.IR_VALID, bus.IR_PC); end end
        default: ;
      endcase
      @(negedge CLK);
    end
    bus.REDIRECT = 1'b0;
  endtask

  task automatic test_wrap_gnt();
    lat = 1; bus.IMEM_GNT = 1'b0; bus.DEC_READY = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.REDIRECT    = (k == 0);
      bus.REDIRECT_PC = 32'hFFFF_FFFC;
      bus.IMEM_GNT    = (k >= 2);
      #1;
      case (k)
        1: begin checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'hFFFF_FFFC || bus.PC_WRITE !== 1'b0) begin errors++; $display("FAIL wrap_nogrant: got req=%b addr=%h pcw=%b want 1 fffffffc 0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.PC_WRITE); end end
        2: begin
          checks++; if (bus.PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_hold: got %h want fffffffc", bus.PC); end
          checks++; if (bus.PC_WRITE !== 1'b1 || bus.PC_NEXT !== 32'h0) begin errors++; $display("FAIL wrap_next: got pcw=%b next=%h want 1 00000000", bus.PC_WRITE, bus.PC_NEXT); end
        end
        3: begin checks++; if (bus.PC !== 32'h0 || bus.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL wrap_pc0: got pc=%h addr=%h want 0 0", bus.PC, bus.IMEM_ADDR); end end
        4: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'hFFFF_FFFC || bus.IR !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_ir: got vld=%b pc=%h ir=%h want 1 fffffffc 0ffffffc", bus.IR_VALID, bus.IR_PC, bus.IR); end end
        5: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h0) begin errors++; $display("FAIL wrap_ir0: got vld=%b pc=%h want 1 0", bus.IR_VALID, bus.IR_PC); end end
        default: ;
      endcase
      @(negedge CLK);
    end
    bus.REDIRECT = 1'b0;
  endtask

  task automatic test_reset_pending();
    lat = 3; bus.IMEM_GNT = 1'b1; bus.DEC_READY = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      RESET        = (k == 4);
      bus.IMEM_GNT = (k <= 2) || (k >= 7);
      force_rv     = (k == 5) || (k == 6);
      lat          = (k >= 7) ? 1 : 3;
      #1;
      case (k)
        4: begin checks++; if (bus.IMEM_REQ !== 1'b0 || bus.PC_WRITE !== 1'b0) begin errors++; $display("FAIL rstp_during: got req=%b pcw=%b want 0 0", bus.IMEM_REQ, bus.PC_WRITE); end end
        5: begin
          checks++; if (bus.IR_VALID !== 1'b0 || bus.IR !== 32'h13 || bus.IR_PC !== 32'h0) begin errors++; $display("FAIL rstp_after: got vld=%b ir=%h pc=%h want 0 00000013 0", bus.IR_VALID, bus.IR, bus.IR_PC); end
          checks++; if (bus.IMEM_RVALID !== 1'b1 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rstp_late_rsp: got rv=%b req=%b addr=%h want 1 1 0", bus.IMEM_RVALID, bus.IMEM_REQ, bus.IMEM_ADDR); end
        end
        7: begin checks++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL rstp_restart: got req=%b addr=%h want 1 0", bus.IMEM_REQ, bus.IMEM_ADDR); end end
        9: begin checks++; if (bus.IR_VALID !== 1'b1 || bus.IR_PC !== 32'h0 || bus.IR !== 32'h1000_0000) begin errors++; $display("FAIL rstp_first_ir: got vld=%b pc=%h ir=%h want 1 0 10000000", bus.IR_VALID, bus.IR_PC, bus.IR); end end
        default: ;
      endcase
      if (k >= 6 && k <= 8) begin
        checks++; if (bus.IR_VALID !== 1'b0) begin errors++; $display("FAIL rstp_ignored c%0d: got vld=%b ir=%h want vld 0", k, bus.IR_VALID, bus.IR); end
      end
      @(negedge CLK);
    end
    force_rv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_pop();
    test_wrap_gnt();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
